// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst reader that streams bytes from a combinational ROM
// One byte per cycle under backpressure; out-of-range bursts are rejected with an err pulse.
module rom_burst_reader #(
  parameter int MAX_ADDR = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  output logic [15:0] rom_address,
  output logic        rom_ce,
  output logic        rom_read_en,
  input  logic [7:0]  rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        abort,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t      r_state;
  logic [15:0] r_cur_addr;
  logic [8:0]  r_remaining;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_err;

  logic [8:0]  w_len;
  logic [16:0] w_end;
  logic        w_in_range;
  logic        w_fetch;

  // 17-bit end address so a start near 0xFFFF cannot wrap into range
  assign w_len      = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
  assign w_end      = {1'b0, cmd_addr} + {8'd0, w_len} - 17'd1;
  assign w_in_range = (w_end <= 17'(MAX_ADDR));

  assign w_fetch = !rst && ((r_state == FETCH) ||
                            (r_state == SEND && out_ready && !r_out_last && !abort));

  assign cmd_ready   = !rst && (r_state == IDLE);
  assign busy        = !rst && (r_state != IDLE);
  assign rom_ce      = w_fetch;
  assign rom_read_en = w_fetch;
  assign rom_address = r_cur_addr;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign err         = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur_addr  <= 16'd0;
      r_remaining <= 9'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (w_in_range) begin
              r_cur_addr  <= cmd_addr;
              r_remaining <= w_len;
              r_state     <= FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        FETCH, SEND: begin
          if (abort) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end else if (w_fetch) begin
            r_out_data  <= rom_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_remaining == 9'd1);
            r_remaining <= r_remaining - 9'd1;
            // address parks on the final byte so it never passes MAX_ADDR
            if (r_remaining != 9'd1) r_cur_addr <= r_cur_addr + 16'd1;
            r_state     <= SEND;
          end else if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - scoreboard bench for rom_burst_reader
// Stimulus pushes expected bytes from a ROM array model; a negedge monitor pops and compares.
module tb_rom_burst_reader;

  localparam int MAX_ADDR = 20000;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] rom_address;
  logic        rom_ce;
  logic        rom_read_en;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        abort;
  logic        busy;
  logic        err;

  logic [7:0]  mem [0:65535];
  logic [8:0]  q [$];
  int          total = 0;
  int          bad = 0;
  int          hs_cnt = 0;
  int          rom_cnt = 0;
  int          mode = 0;
  int          pat = 0;

  rom_burst_reader #(.MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rom_address(rom_address), .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .abort(abort), .busy(busy), .err(err)
  );

  assign rom_data = mem[rom_address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time expired expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // out_ready pattern: 0 = always ready, 1 = random, 2 = repeating 1,0,0
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom % 2);
        default: begin
          out_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
      endcase
    end
  end

  initial begin
    logic [8:0] prev;
    logic [8:0] e_byte;
    bit have_prev;
    have_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rom_ce) rom_cnt++;
      if (busy) chk("ce_eq_read_en", rom_read_en, rom_ce);
      if (rst || (abort && busy)) begin
        q.delete();
        have_prev = 1'b0;
      end else if (out_valid) begin
        if (have_prev) chk("hold_stable", {out_last, out_data}, prev);
        if (out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %0h expected no byte", out_data);
          end else begin
            e_byte = q.pop_front();
            chk("byte", {out_last, out_data}, e_byte);
          end
          hs_cnt++;
          have_prev = 1'b0;
        end else begin
          chk("no_rom_while_stalled", rom_ce, 0);
          prev = {out_last, out_data};
          have_prev = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: busy=%0b queued=%0d expected idle and empty", busy, q.size());
  endtask

  // Returns at the negedge where the first byte is on out_valid (accepted) or after err drops.
  task automatic send_cmd(input logic [15:0] a, input logic [7:0] l);
    int  n;
    bit  rej;
    bit  ready_seen;
    n = (l == 8'd0) ? 256 : int'(l);
    rej = (int'(a) + n - 1) > MAX_ADDR;
    ready_seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ready_seen = 1'b1;
        break;
      end
    end
    if (!ready_seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: cmd_ready=0 expected 1");
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    chk("cmd_ready_at_accept", cmd_ready, 1);
    if (!rej)
      for (int i = 0; i < n; i++) q.push_back({(i == n - 1), mem[16'(int'(a) + i)]});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (rej) begin
      chk("err_pulse", err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_out_valid", out_valid, 0);
      @(negedge clk);
      chk("err_single", err, 0);
      chk("rej_no_valid", out_valid, 0);
    end else begin
      chk("lat_c1_valid", out_valid, 0);
      chk("lat_c1_busy", busy, 1);
      chk("lat_c1_err", err, 0);
      @(negedge clk);
      chk("lat_c2_valid", out_valid, 1);
    end
  endtask

  initial begin
    int rc0;
    int hc0;
    int cnt;
    logic [15:0] ra;
    logic [7:0]  rl;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = 16'd0;
    cmd_len = 8'd0;
    abort = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_ce", rom_ce, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rom_address", rom_address, 0);
    chk("idle_out_data", out_data, 0);
    chk("idle_out_last", out_last, 0);

    // basic 4-byte burst, always ready
    mode = 0;
    rc0 = rom_cnt;
    send_cmd(16'h0010, 8'd4);
    chk("b4_valid0", out_valid, 1);
    chk("b4_last0", out_last, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("b4_valid", out_valid, 1);
      chk("b4_last", out_last, (i == 3));
    end
    @(negedge clk);
    chk("b4_done_ready", cmd_ready, 1);
    chk("b4_done_valid", out_valid, 0);
    chk("b4_rom_enables", rom_cnt - rc0, 4);

    // backpressure 1,0,0
    mode = 2;
    rc0 = rom_cnt;
    hc0 = hs_cnt;
    send_cmd(16'h0040, 8'd3);
    wait_idle(200);
    chk("bp_rom_enables", rom_cnt - rc0, 3);
    chk("bp_bytes", hs_cnt - hc0, 3);

    // range boundaries
    mode = 0;
    hc0 = hs_cnt;
    send_cmd(16'd19999, 8'd2);
    wait_idle(200);
    chk("edge_accept_bytes", hs_cnt - hc0, 2);
    rc0 = rom_cnt;
    send_cmd(16'd19999, 8'd3);
    send_cmd(16'hFFFF, 8'd0);
    chk("rej_no_rom", rom_cnt - rc0, 0);
    chk("rej_no_bytes", hs_cnt - hc0, 2);

    // 256-byte burst
    hc0 = hs_cnt;
    send_cmd(16'h0000, 8'd0);
    wait_idle(600);
    chk("len256_bytes", hs_cnt - hc0, 256);

    // abort on second byte
    send_cmd(16'h0200, 8'd8);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_byte_present", out_valid, 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last", out_last, 0);
    chk("abort_ready", cmd_ready, 1);
    hc0 = hs_cnt;
    send_cmd(16'h0300, 8'd2);
    wait_idle(200);
    chk("after_abort_bytes", hs_cnt - hc0, 2);

    // reset mid-burst
    send_cmd(16'h0100, 8'd8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("inrst_rom_ce", rom_ce, 0);
    chk("inrst_read_en", rom_read_en, 0);
    chk("inrst_cmd_ready", cmd_ready, 0);
    chk("inrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_err", err, 0);
    chk("mrst_addr", rom_address, 0);
    chk("mrst_busy", busy, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy) cnt++;
    end
    chk("no_resume", cnt, 0);

    // randomized bursts with random backpressure
    mode = 1;
    for (int k = 0; k < 25; k++) begin
      case ($urandom % 4)
        0: ra = 16'($urandom_range(0, MAX_ADDR));
        1: ra = 16'(MAX_ADDR - int'($urandom_range(0, 50)));
        2: ra = 16'($urandom);
        default: ra = 16'($urandom_range(0, 1000));
      endcase
      rl = ($urandom % 6 == 0) ? 8'($urandom) : 8'($urandom_range(1, 40));
      send_cmd(ra, rl);
      wait_idle(2000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
